// File: rtl/rd_adder_pipe.sv
// rd_adder_pipe: fully pipelined Kogge-Stone (recursive-doubling) adder/subtractor.
// Each position 0..WIDTH carries a 2-bit carry status (K=00, P=10, G=11; 01 reads
// as P). The status vector is registered at the input, then one registered stage
// per doubling distance (1, 2, 4, ...) resolves every P. A final registered stage
// forms sum, carry-out and signed overflow. A tag rides alongside each operation.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
// The whole pipe moves as one (advance = !out_valid | out_ready, in_ready = advance);
// when it stalls every stage holds. Each stage has its own valid bit, so bubbles
// travel through as empty slots and the output stays stable while it waits.
module rd_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    // Number of doubling steps needed to span all WIDTH+1 positions.
    localparam int S = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_K = 2'b00;
    localparam logic [1:0] ST_P = 2'b10;
    localparam logic [1:0] ST_G = 2'b11;

    typedef logic [WIDTH:0][1:0] stat_t;

    // A position that propagates takes its status from the lower span; otherwise
    // it already knows its own carry.
    function automatic logic [1:0] combine(input logic [1:0] prev, input logic [1:0] cur);
        return (cur[1] ^ cur[0]) ? prev : cur;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    stat_t            st_in;

    stat_t            st_q  [0:S];
    logic [WIDTH-1:0] h_q   [0:S];
    logic [TAG_W-1:0] tag_q [0:S];
    logic [S:0]       vld_q;
    stat_t            st_nxt [0:S-1];

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand prep and initial per-position carry status.
    always_comb begin
        b_eff    = in_sub ? ~in_b : in_b;
        c0       = in_sub ? 1'b1 : in_cin;
        st_in    = '0;
        st_in[0] = c0 ? ST_G : ST_K;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_a[i] && b_eff[i])
                st_in[i+1] = ST_G;
            else if (in_a[i] ^ b_eff[i])
                st_in[i+1] = ST_P;
            else
                st_in[i+1] = ST_K;
        end
    end

    // Doubling step k combines each position with the one 2^k below it.
    always_comb begin
        for (int k = 0; k < S; k++) begin
            st_nxt[k] = st_q[k];
            for (int j = 0; j <= WIDTH; j++) begin
                if (j >= (1 << k))
                    st_nxt[k][j] = combine(st_q[k][j - (1 << k)], st_q[k][j]);
            end
        end
    end

    // After the last step no P remains: a position's carry is set iff it is G.
    always_comb begin
        carry = '0;
        for (int j = 0; j <= WIDTH; j++)
            carry[j] = (st_q[S][j] == ST_G);
        sum_nxt = h_q[S] ^ carry[WIDTH-1:0];
    end

    // Pipeline registers: input stage, S doubling stages, and the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            st_q[0]  <= st_in;
            h_q[0]   <= in_a ^ b_eff;
            tag_q[0] <= in_tag;
            for (int k = 0; k < S; k++) begin
                vld_q[k+1] <= vld_q[k];
                st_q[k+1]  <= st_nxt[k];
                h_q[k+1]   <= h_q[k];
                tag_q[k+1] <= tag_q[k];
            end
            out_valid <= vld_q[S];
            if (vld_q[S]) begin
                out_sum  <= sum_nxt;
                out_cout <= carry[WIDTH];
                out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
                out_tag  <= tag_q[S];
            end
        end
    end

endmodule

// File: tb/tb_rd_adder_pipe.sv
// Bench for rd_adder_pipe: WIDTH=16 instance for most scenarios, WIDTH=8 instance
// for the narrow-width latency case. Expected results come from plain integer
// arithmetic in ref_add.
module tb_rd_adder_pipe;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int W     = TAG_W + 2 + WIDTH;
    localparam int LAT16 = 7;
    localparam int LAT8  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // WIDTH=16 instance signals
    logic             in_valid, in_ready, in_cin, in_sub;
    logic [WIDTH-1:0] in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_cout, out_ovf;
    logic [WIDTH-1:0] out_sum;
    logic [TAG_W-1:0] out_tag;

    // WIDTH=8 instance signals
    logic             w8_in_valid, w8_in_ready, w8_in_cin, w8_in_sub;
    logic [7:0]       w8_in_a, w8_in_b;
    logic [TAG_W-1:0] w8_in_tag;
    logic             w8_out_valid, w8_out_ready, w8_out_cout, w8_out_ovf;
    logic [7:0]       w8_out_sum;
    logic [TAG_W-1:0] w8_out_tag;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    rd_adder_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    rd_adder_pipe #(.WIDTH(8), .TAG_W(TAG_W)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .in_a(w8_in_a), .in_b(w8_in_b), .in_cin(w8_in_cin), .in_sub(w8_in_sub), .in_tag(w8_in_tag),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .out_sum(w8_out_sum), .out_cout(w8_out_cout), .out_ovf(w8_out_ovf), .out_tag(w8_out_tag)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    // A + B + cin, or A - B as A + ~B + 1, on w-bit operands.
    function automatic res_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
        logic [32:0] full;
        logic [31:0] mask, am, bp;
        res_t r;
        mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am     = a & mask;
        bp     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bp} + {32'b0, (sub ? 1'b1 : cin)};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bp[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one op to the 16-bit DUT on an empty pipe and waits for its result.
    // lat counts edges starting with the accept edge as 1. Called at posedge+1.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [TAG_W-1:0] tag,
                          output logic [15:0] s, output logic co, output logic ov,
                          output logic [TAG_W-1:0] tg, output int lat);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        s = out_sum; co = out_cout; ov = out_ovf; tg = out_tag;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
        in_cin = 1'b1; in_sub = 1'b0; in_tag = 4'hA; out_ready = 1'b1;
        w8_in_valid = 1'b1; w8_in_a = 8'($urandom); w8_in_b = 8'($urandom);
        w8_in_cin = 1'b0; w8_in_sub = 1'b0; w8_in_tag = 4'h3; w8_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; w8_in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset_out_sum got %h exp 0000", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b exp 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (w8_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w8_out_valid got %b exp 0", w8_out_valid); end
        // Inputs offered during reset must never produce a result.
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid || w8_out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ignored_in_reset got %b exp 0", seen); end
    endtask

    task automatic test_directed();
        logic [15:0] da[5]  = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'h0003};
        logic [15:0] db[5]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0005};
        logic        dci[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        dsb[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] es[5]  = '{16'h0000, 16'h7FFF, 16'h8000, 16'h1235, 16'hFFFE};
        logic        ec[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eo[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] s;
        logic co, ov;
        logic [TAG_W-1:0] tg, et;
        int lat;
        for (int i = 0; i < 5; i++) begin
            et = TAG_W'(i + 1);
            send16(da[i], db[i], dci[i], dsb[i], et, s, co, ov, tg, lat);
            checks++; if (lat != LAT16) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT16); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, s, es[i]); end
            checks++; if (co !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, co, ec[i]); end
            checks++; if (ov !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", i, ov, eo[i]); end
            checks++; if (tg !== et) begin errors++; $display("FAIL dir%0d_tag got %h exp %h", i, tg, et); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] sa[20], sb[20];
        logic        scin[20], ssub[20];
        int sent, got, c;
        logic prev_stall, exp_rdy;
        logic [W-1:0] held, obs, exp_v;
        res_t r;
        for (int i = 0; i < 20; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom);
            scin[i] = 1'($urandom_range(0, 1)); ssub[i] = 1'($urandom_range(0, 1));
        end
        sa[3] = 16'h8000; sb[3] = 16'h8000; ssub[3] = 1'b0;
        sent = 0; got = 0; c = 0; prev_stall = 1'b0; held = '0;
        exp_q.delete();
        while (got < 20 && c < 100) begin
            if (sent < 20) begin
                in_valid = 1'b1; in_a = sa[sent]; in_b = sb[sent];
                in_cin = scin[sent]; in_sub = ssub[sent]; in_tag = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 10 && c <= 13);
            @(negedge clk);
            obs = {out_tag, out_ovf, out_cout, out_sum};
            exp_rdy = !(c >= 10 && c <= 13);
            if (c < 30) begin
                checks++;
                if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b exp %b", c, in_ready, exp_rdy); end
            end
            if (prev_stall) begin
                checks++;
                if (obs !== held) begin errors++; $display("FAIL b2b_hold cycle %0d got %h exp %h", c, obs, held); end
            end
            prev_stall = out_valid && !out_ready;
            held = obs;
            if (in_valid && in_ready) begin
                r = ref_add(16, {16'h0, sa[sent]}, {16'h0, sb[sent]}, scin[sent], ssub[sent]);
                exp_q.push_back({sent[3:0], r.ovf, r.cout, r.sum[15:0]});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_result got %h exp none", obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin errors++; $display("FAIL b2b_result%0d got %h exp %h", got, obs, exp_v); end
                end
                got++;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 20 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d exp 20 (left %0d)", got, exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        logic seen;
        logic [15:0] s;
        logic co, ov;
        logic [TAG_W-1:0] tg;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            in_cin = 1'b0; in_sub = 1'b0; in_tag = TAG_W'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        seen = out_valid;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_stale_result got %b exp 0", seen); end
        send16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 4'h9, s, co, ov, tg, lat);
        checks++; if (lat != LAT16) begin errors++; $display("FAIL flush_latency got %0d exp %0d", lat, LAT16); end
        checks++; if ({tg, ov, co, s} !== {4'h9, 1'b0, 1'b0, 16'h1000}) begin
            errors++; $display("FAIL flush_result got %h exp %h", {tg, ov, co, s}, {4'h9, 1'b0, 1'b0, 16'h1000});
        end
    endtask

    task automatic test_width8();
        logic [7:0] a8[5], b8[5];
        logic       ci8[5], sb8[5];
        int lat;
        res_t r;
        a8[0] = 8'hAA; b8[0] = 8'h55; ci8[0] = 1'b1; sb8[0] = 1'b0;
        for (int i = 1; i < 5; i++) begin
            a8[i] = 8'($urandom); b8[i] = 8'($urandom);
            ci8[i] = 1'($urandom_range(0, 1)); sb8[i] = 1'($urandom_range(0, 1));
        end
        w8_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                r.sum = 32'h0; r.cout = 1'b1; r.ovf = 1'b0;
            end else begin
                r = ref_add(8, {24'h0, a8[i]}, {24'h0, b8[i]}, ci8[i], sb8[i]);
            end
            w8_in_a = a8[i]; w8_in_b = b8[i]; w8_in_cin = ci8[i]; w8_in_sub = sb8[i];
            w8_in_tag = TAG_W'(i + 5); w8_in_valid = 1'b1;
            @(posedge clk); #1;
            w8_in_valid = 1'b0;
            lat = 1;
            while (!w8_out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (lat != LAT8) begin errors++; $display("FAIL w8_%0d_latency got %0d exp %0d", i, lat, LAT8); end
            checks++; if ({w8_out_tag, w8_out_ovf, w8_out_cout, w8_out_sum} !== {TAG_W'(i + 5), r.ovf, r.cout, r.sum[7:0]}) begin
                errors++;
                $display("FAIL w8_%0d_result got %h exp %h", i, {w8_out_tag, w8_out_ovf, w8_out_cout, w8_out_sum},
                         {TAG_W'(i + 5), r.ovf, r.cout, r.sum[7:0]});
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        w8_in_valid = 1'b0; w8_in_a = '0; w8_in_b = '0; w8_in_cin = 1'b0; w8_in_sub = 1'b0;
        w8_in_tag = '0; w8_out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so a wedged run still ends.
    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
